// File: rtl/instr_fetch_unit_if.sv
// Instruction fetch unit bus: memory request/response channel plus the
// fetched-word output channel toward the decoder.
interface instr_fetch_unit_if;
   logic [63:0] instr_if_address_o;
   logic        instr_if_data_req_o;
   logic [3:0]  instr_if_data_be_o;
   logic        instr_if_data_gnt_i;
   logic        instr_if_data_rvalid_i;
   logic [63:0] instr_if_data_rdata_i;
   logic        fetch_valid_o;
   logic [63:0] fetch_rdata_o;
   logic [63:0] fetch_addr_o;
   logic        fetch_ready_i;

   modport master (
      output instr_if_address_o, instr_if_data_req_o, instr_if_data_be_o,
      output fetch_valid_o, fetch_rdata_o, fetch_addr_o,
      input  instr_if_data_gnt_i, instr_if_data_rvalid_i, instr_if_data_rdata_i,
      input  fetch_ready_i
   );

   modport slave (
      input  instr_if_address_o, instr_if_data_req_o, instr_if_data_be_o,
      input  fetch_valid_o, fetch_rdata_o, fetch_addr_o,
      output instr_if_data_gnt_i, instr_if_data_rvalid_i, instr_if_data_rdata_i,
      output fetch_ready_i
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Credit-based instruction prefetcher: issues 8-byte fetches, buffers the
// in-order responses with their addresses, and drops in-flight data on flush.
module instr_fetch_unit #(
   parameter int FIFO_DEPTH      = 4,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [63:0]        boot_addr_i,
   input  logic               flush_i,
   input  logic [63:0]        flush_addr_i,
   instr_fetch_unit_if.master bus
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int OS_W  = $clog2(MAX_OUTSTANDING + 1);
   localparam int AQ_W  = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_e;

   state_e                              state_q;
   logic [63:0]                         pc_q;
   logic [OS_W-1:0]                     outstanding_q, discard_q;
   logic [CNT_W-1:0]                    count_q;
   logic [PTR_W-1:0]                    rd_ptr_q, wr_ptr_q;
   logic [FIFO_DEPTH-1:0][63:0]         data_q, addr_q;
   logic [MAX_OUTSTANDING-1:0][63:0]    aq_q;
   logic [AQ_W-1:0]                     aq_rd_q, aq_wr_q;

   logic [CNT_W-1:0] free_slots;
   logic             credit_ok, req, gnt_fire, rv_take, rv_drop;
   logic             full, push, wr_en, pop;
   logic [OS_W:0]    inflight_nxt;
   logic [AQ_W-1:0]  aq_rd_inc, aq_wr_inc;
   logic             unused_lsbs;

   assign unused_lsbs = ^{boot_addr_i[2:0], flush_addr_i[2:0]};

   assign free_slots = CNT_W'(FIFO_DEPTH) - count_q;
   assign credit_ok  = (free_slots > CNT_W'(outstanding_q)) &&
                       (outstanding_q < OS_W'(MAX_OUTSTANDING));
   // req is combinational so a flush can withdraw it in the same cycle
   assign req      = (state_q == FETCH) && !flush_i && credit_ok;
   assign gnt_fire = req && bus.instr_if_data_gnt_i;

   // Responses with nothing outstanding (e.g. left over from before reset) are ignored
   assign rv_take = bus.instr_if_data_rvalid_i && (state_q == FETCH) && (outstanding_q != '0);
   assign rv_drop = bus.instr_if_data_rvalid_i && (state_q == DRAIN);

   assign full  = (count_q == CNT_W'(FIFO_DEPTH));
   assign push  = rv_take && !flush_i;
   assign wr_en = push && !full;
   assign pop   = (count_q != '0) && bus.fetch_ready_i && !flush_i;

   // Everything still owed by memory after this cycle; becomes the discard count on flush
   assign inflight_nxt = (OS_W+1)'(discard_q) + (OS_W+1)'(outstanding_q)
                       + (OS_W+1)'(gnt_fire) - (OS_W+1)'(rv_take | rv_drop);

   assign aq_rd_inc = (aq_rd_q == AQ_W'(MAX_OUTSTANDING - 1)) ? '0 : aq_rd_q + AQ_W'(1);
   assign aq_wr_inc = (aq_wr_q == AQ_W'(MAX_OUTSTANDING - 1)) ? '0 : aq_wr_q + AQ_W'(1);

   assign bus.instr_if_address_o  = (state_q == IDLE) ? '0 : pc_q;
   assign bus.instr_if_data_req_o = req;
   assign bus.instr_if_data_be_o  = 4'hF;
   assign bus.fetch_valid_o       = (count_q != '0);
   assign bus.fetch_rdata_o       = data_q[rd_ptr_q];
   assign bus.fetch_addr_o        = addr_q[rd_ptr_q];

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q       <= IDLE;
         pc_q          <= {boot_addr_i[63:3], 3'b000};
         outstanding_q <= '0;
         discard_q     <= '0;
         count_q       <= '0;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         aq_rd_q       <= '0;
         aq_wr_q       <= '0;
      end else if (flush_i) begin
         pc_q          <= {flush_addr_i[63:3], 3'b000};
         outstanding_q <= '0;
         discard_q     <= OS_W'(inflight_nxt);
         count_q       <= '0;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         aq_rd_q       <= '0;
         aq_wr_q       <= '0;
         state_q       <= (inflight_nxt == '0) ? FETCH : DRAIN;
      end else begin
         if (gnt_fire) begin
            pc_q    <= pc_q + 64'd8;
            aq_wr_q <= aq_wr_inc;
         end
         if (rv_take) aq_rd_q <= aq_rd_inc;
         outstanding_q <= outstanding_q + OS_W'(gnt_fire) - OS_W'(rv_take);
         if (wr_en) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)   rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         count_q <= count_q + CNT_W'(wr_en) - CNT_W'(pop);
         case (state_q)
            IDLE:    state_q <= FETCH;
            FETCH:   state_q <= FETCH;
            DRAIN: begin
               if (rv_drop) begin
                  discard_q <= discard_q - OS_W'(1);
                  if (discard_q == OS_W'(1)) state_q <= FETCH;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Storage is reset so the head outputs read zero while in reset
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         data_q <= '0;
         addr_q <= '0;
         aq_q   <= '0;
      end else begin
         if (wr_en) begin
            data_q[wr_ptr_q] <= bus.instr_if_data_rdata_i;
            addr_q[wr_ptr_q] <= aq_q[aq_rd_q];
         end
         if (gnt_fire) aq_q[aq_wr_q] <= pc_q;
      end
   end

   a_no_push_when_full: assert property (@(posedge clk_i) disable iff (rst_i) !(push && full));

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a latency-modelled memory responds to
// grants, expected {addr,data} words are queued on grant and checked on pop.
module tb_instr_fetch_unit;
   localparam int FD = 4;
   localparam int MO = 2;

   typedef struct {
      logic [63:0] addr;
      int          due;
   } pend_t;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic [63:0] boot_addr_i = 64'h8000_0000;
   logic        flush_i = 1'b0;
   logic [63:0] flush_addr_i = '0;

   instr_fetch_unit_if bus();

   instr_fetch_unit #(.FIFO_DEPTH(FD), .MAX_OUTSTANDING(MO)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .boot_addr_i (boot_addr_i),
      .flush_i     (flush_i),
      .flush_addr_i(flush_addr_i),
      .bus         (bus)
   );

   always #5 clk_i = ~clk_i;

   pend_t       pend_q[$];
   logic [63:0] exp_q[$];
   logic [63:0] glog[$];
   int          n_chk = 0, n_pass = 0, cyc = 0, lat = 1;
   bit          gnt_on = 1'b0, rdy = 1'b0, stray = 1'b0, rnd = 1'b0;
   logic        req_at_flush = 1'b0;

   function automatic logic [63:0] mdata(input logic [63:0] a);
      return {a[31:0] ^ 32'h5EED_1234, a[63:32] ^ 32'hC0FF_EE00};
   endfunction

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
   endtask

   // One clock cycle, entered and left at a falling edge
   task automatic step(input bit fl = 1'b0, input logic [63:0] fa = '0);
      logic [63:0] e;
      flush_i      = fl;
      flush_addr_i = fa;
      bus.instr_if_data_gnt_i    = rnd ? 1'($urandom_range(0, 1)) : gnt_on;
      bus.fetch_ready_i          = rnd ? ($urandom_range(0, 3) != 0) : rdy;
      bus.instr_if_data_rvalid_i = 1'b0;
      bus.instr_if_data_rdata_i  = '0;
      if (stray) begin
         bus.instr_if_data_rvalid_i = 1'b1;
         bus.instr_if_data_rdata_i  = 64'hBAD0_BAD0_BAD0_BAD0;
      end else if (pend_q.size() > 0 && pend_q[0].due <= cyc &&
                   (!rnd || $urandom_range(0, 3) != 0)) begin
         bus.instr_if_data_rvalid_i = 1'b1;
         bus.instr_if_data_rdata_i  = mdata(pend_q[0].addr);
         void'(pend_q.pop_front());
      end
      #1;
      if (!rst_i) begin
         if (fl) begin
            req_at_flush = bus.instr_if_data_req_o;
            exp_q.delete();
         end else if (bus.fetch_valid_o && bus.fetch_ready_i) begin
            if (exp_q.size() == 0) chk("sb_unexpected_word", 64'(bus.fetch_valid_o), 64'd0);
            else begin
               e = exp_q.pop_front();
               chk("sb_addr", bus.fetch_addr_o, e);
               chk("sb_data", bus.fetch_rdata_o, mdata(e));
            end
         end
         if (bus.instr_if_data_req_o && bus.instr_if_data_gnt_i) begin
            exp_q.push_back(bus.instr_if_address_o);
            pend_q.push_back('{addr: bus.instr_if_address_o, due: cyc + lat});
            glog.push_back(bus.instr_if_address_o);
         end
      end
      @(posedge clk_i);
      cyc++;
      @(negedge clk_i);
   endtask

   task automatic do_reset(input logic [63:0] boot);
      rst_i        = 1'b1;
      boot_addr_i  = boot;
      flush_i      = 1'b0;
      bus.instr_if_data_gnt_i    = 1'b0;
      bus.instr_if_data_rvalid_i = 1'b0;
      bus.fetch_ready_i          = 1'b0;
      exp_q.delete();
      pend_q.delete();
      glog.delete();
      repeat (2) @(negedge clk_i);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected $finish");
      $fatal(1);
   end

   initial begin
      int  n;
      bit  saw_valid;
      logic [63:0] a;
      bus.instr_if_data_gnt_i    = 1'b0;
      bus.instr_if_data_rvalid_i = 1'b0;
      bus.instr_if_data_rdata_i  = '0;
      bus.fetch_ready_i          = 1'b0;

      // Reset state
      do_reset(64'h8000_0000);
      chk("rst_req",   64'(bus.instr_if_data_req_o), 64'd0);
      chk("rst_addr",  bus.instr_if_address_o, 64'd0);
      chk("rst_valid", 64'(bus.fetch_valid_o), 64'd0);
      chk("rst_rdata", bus.fetch_rdata_o, 64'd0);
      chk("rst_faddr", bus.fetch_addr_o, 64'd0);
      chk("rst_be",    64'(bus.instr_if_data_be_o), 64'hF);

      // Streaming from boot address, first word latency
      gnt_on = 1'b1; rdy = 1'b1; lat = 1;
      rst_i = 1'b0;
      n = 0;
      while (!bus.fetch_valid_o && n < 10) begin step(); n++; end
      chk("first_valid_latency", 64'(n), 64'd3);
      chk("first_head_addr", bus.fetch_addr_o, 64'h8000_0000);
      chk("req0_addr", glog[0], 64'h8000_0000);
      chk("req1_addr", glog[1], 64'h8000_0008);
      chk("run_be", 64'(bus.instr_if_data_be_o), 64'hF);
      repeat (20) step();

      // Buffer fills with consumer stalled, then one pop frees one credit
      do_reset(64'h8000_0000);
      gnt_on = 1'b1; rdy = 1'b0; lat = 1;
      rst_i = 1'b0;
      repeat (12) step();
      chk("full_grants", 64'(glog.size()), 64'd4);
      chk("full_req_low", 64'(bus.instr_if_data_req_o), 64'd0);
      chk("full_head", bus.fetch_addr_o, 64'h8000_0000);
      rdy = 1'b1; step(); rdy = 1'b0;
      chk("refill_req", 64'(bus.instr_if_data_req_o), 64'd1);
      chk("refill_addr", bus.instr_if_address_o, 64'h8000_0020);
      repeat (4) step();
      chk("refill_grants", 64'(glog.size()), 64'd5);
      chk("refill_req_low", 64'(bus.instr_if_data_req_o), 64'd0);

      // Grant withheld: request must hold its address
      gnt_on = 1'b0; rdy = 1'b1;
      step();
      a = bus.instr_if_address_o;
      chk("stall_addr_first", a, 64'h8000_0028);
      for (int i = 0; i < 5; i++) begin
         chk("stall_req", 64'(bus.instr_if_data_req_o), 64'd1);
         chk("stall_addr", bus.instr_if_address_o, a);
         step();
      end
      gnt_on = 1'b1;
      step();
      chk("stall_granted_addr", glog[$], a);
      chk("stall_pc_next", bus.instr_if_address_o, a + 64'd8);

      // Flush with two fetches in flight
      lat = 4;
      n = 0;
      while (pend_q.size() != 2 && n < 20) begin step(); n++; end
      chk("flush_setup_inflight", 64'(pend_q.size()), 64'd2);
      glog.delete();
      step(1'b1, 64'h1004);
      chk("flush_req_low", 64'(req_at_flush), 64'd0);
      n = 0; saw_valid = 1'b0;
      while (glog.size() == 0 && n < 30) begin
         saw_valid |= bus.fetch_valid_o;
         step(); n++;
      end
      chk("flush_next_req", (glog.size() > 0) ? glog[0] : 64'hDEAD, 64'h1000);
      chk("flush_drained_first", 64'(pend_q.size()), 64'd1);
      chk("flush_no_valid", 64'(saw_valid), 64'd0);
      n = 0;
      while (!bus.fetch_valid_o && n < 20) begin step(); n++; end
      chk("flush_head_addr", bus.fetch_addr_o, 64'h1000);
      repeat (6) step();

      // Address wrap at top of memory
      do_reset(64'hFFFF_FFFF_FFFF_FFF8);
      gnt_on = 1'b1; rdy = 1'b1; lat = 1;
      rst_i = 1'b0;
      repeat (8) step();
      chk("wrap_req0", glog[0], 64'hFFFF_FFFF_FFFF_FFF8);
      chk("wrap_req1", glog[1], 64'h0);

      // Reset mid-operation with 3 buffered and 1 in flight; unaligned boot
      do_reset(64'h2005);
      gnt_on = 1'b1; rdy = 1'b0; lat = 3;
      rst_i = 1'b0;
      n = 0;
      while (!((glog.size() - pend_q.size()) == 3 && pend_q.size() == 1) && n < 40) begin
         step(); n++;
      end
      chk("mid_setup_valid", 64'(bus.fetch_valid_o), 64'd1);
      chk("mid_head_aligned", bus.fetch_addr_o, 64'h2000);
      rst_i = 1'b1;
      #1;
      chk("mid_rst_valid", 64'(bus.fetch_valid_o), 64'd0);
      chk("mid_rst_req", 64'(bus.instr_if_data_req_o), 64'd0);
      exp_q.delete(); pend_q.delete(); glog.delete();
      bus.instr_if_data_rvalid_i = 1'b0;
      @(posedge clk_i); @(negedge clk_i);
      rst_i = 1'b0;
      gnt_on = 1'b0; stray = 1'b1;
      step(); step();
      stray = 1'b0;
      step(); step();
      chk("stray_not_pushed", 64'(bus.fetch_valid_o), 64'd0);
      gnt_on = 1'b1; rdy = 1'b1; lat = 1;
      repeat (10) step();

      // Random grants, latencies, back-pressure and flushes
      rnd = 1'b1;
      for (int i = 0; i < 300; i++) begin
         lat = $urandom_range(1, 3);
         if ($urandom_range(0, 29) == 0) step(1'b1, {$urandom, $urandom});
         else step();
      end
      rnd = 1'b0; gnt_on = 1'b0; rdy = 1'b1;
      n = 0;
      while ((exp_q.size() != 0 || pend_q.size() != 0) && n < 60) begin step(); n++; end
      step(); step();
      chk("final_drain", 64'(exp_q.size()), 64'd0);
      chk("final_valid_low", 64'(bus.fetch_valid_o), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
